lvds_deserializer: RTL

//   Receive-side counterpart of the LVDS byte serializer. Accepts the forwarded link clock plus
//   one DDR bit pair per cycle, locks to the idle/sync framing, and rebuilds bytes MSB first.

---
 rtl/lvds_deserializer_if.sv | 10 +
 rtl/lvds_deserializer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/lvds_deserializer_if.sv
// Byte stream from the deserializer FIFO to the downstream sample logic.
// master: deserializer (drives data/valid); slave: consumer (drives ready).
interface lvds_deserializer_if;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/lvds_deserializer.sv
// LVDS byte deserializer: locks to idle/sync framing on DDR bit pairs, rebuilds bytes
// MSB first and queues them in a first-word-fall-through FIFO.
// Optional feature macro: DESER_STATS_EN adds frame_cnt / err_cnt statistics ports.
module lvds_deserializer #(
    parameter int unsigned LOCK_IDLE = 16,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     rx_hi,
    input  logic                     rx_lo,
    lvds_deserializer_if.master      bus,
    output logic                     locked,
    output logic                     sync_err,
    output logic                     overflow,
    input  logic                     ovf_clr
`ifdef DESER_STATS_EN
    ,
    output logic [CNT_W-1:0]         frame_cnt,
    output logic [CNT_W-1:0]         err_cnt
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [7:0]       LockIdle = 8'(LOCK_IDLE);
    localparam logic [PTR_W:0]   FullCnt  = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CntOne   = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PtrOne   = PTR_W'(1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of 2 and at least 2");
    end
    if (LOCK_IDLE < 1 || LOCK_IDLE > 255) begin : g_bad_lock
        $error("LOCK_IDLE must be in 1..255");
    end
    if (CNT_W < 1) begin : g_bad_cnt
        $error("CNT_W must be at least 1");
    end

    typedef enum logic [1:0] {StHunt, StData, StSync} state_e;

    logic [1:0] pair;
    assign pair = {rx_hi, rx_lo};

    state_e     state_q, state_d;
    logic [7:0] idle_cnt_q, idle_cnt_d;
    logic [1:0] slot_q, slot_d;
    // Only the first three pairs need storing; the fourth comes straight from the line.
    logic [5:0] shift_q, shift_d;
    logic       locked_q, locked_d;
    logic       sync_err_q, sync_err_d;
    logic       byte_wr;
    logic [7:0] byte_val;

    // Framing next-state: hunt for idle run + sync, collect 4 data pairs, check sync slot.
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        slot_d     = slot_q;
        shift_d    = shift_q;
        locked_d   = locked_q;
        sync_err_d = 1'b0;
        byte_wr    = 1'b0;
        byte_val   = {shift_q, pair};
        unique case (state_q)
            StHunt: begin
                if (pair == 2'b00) begin
                    if (idle_cnt_q < LockIdle) idle_cnt_d = idle_cnt_q + 8'd1;
                end else if (pair == 2'b10 && idle_cnt_q == LockIdle) begin
                    state_d    = StData;
                    slot_d     = 2'd0;
                    locked_d   = 1'b1;
                    idle_cnt_d = 8'd0;
                end else begin
                    idle_cnt_d = 8'd0;
                end
            end
            StData: begin
                shift_d = {shift_q[3:0], pair};
                slot_d  = slot_q + 2'd1;
                if (slot_q == 2'd3) begin
                    byte_wr = 1'b1;
                    state_d = StSync;
                end
            end
            StSync: begin
                if (pair == 2'b10) begin
                    state_d = StData;
                    slot_d  = 2'd0;
                end else if (pair == 2'b00) begin
                    // Link went idle: this pair already counts toward the next lock.
                    state_d    = StHunt;
                    locked_d   = 1'b0;
                    idle_cnt_d = 8'd1;
                end else begin
                    state_d    = StHunt;
                    locked_d   = 1'b0;
                    idle_cnt_d = 8'd0;
                    sync_err_d = 1'b1;
                end
            end
            default: begin
                state_d  = StHunt;
                locked_d = 1'b0;
            end
        endcase
    end

    // Framing state registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StHunt;
            idle_cnt_q <= 8'd0;
            slot_q     <= 2'd0;
            shift_q    <= 6'd0;
            locked_q   <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            slot_q     <= slot_d;
            shift_q    <= shift_d;
            locked_q   <= locked_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign locked   = locked_q;
    assign sync_err = sync_err_q;

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             rd_en, full, push, drop;

    assign rd_en = (count_q != '0) && bus.out_ready;
    assign full  = (count_q == FullCnt);
    // A read in the same cycle frees the slot, so a write to a full FIFO still lands.
    assign push  = byte_wr && (!full || rd_en);
    assign drop  = byte_wr && full && !rd_en;

    // FIFO occupancy and sticky overflow (clear wins over set).
    always_comb begin
        count_d = count_q;
        if (push && !rd_en) begin
            count_d = count_q + CntOne;
        end else if (!push && rd_en) begin
            count_d = count_q - CntOne;
        end
        overflow_d = ovf_clr ? 1'b0 : (overflow_q | drop);
    end

    // FIFO storage, pointers and status registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= 8'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= byte_val;
                wr_ptr_q        <= wr_ptr_q + PtrOne;
            end
            if (rd_en) rd_ptr_q <= rd_ptr_q + PtrOne;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.out_data  = mem_q[rd_ptr_q];
    assign bus.out_valid = (count_q != '0);
    assign overflow      = overflow_q;

`ifdef DESER_STATS_EN
    logic [CNT_W-1:0] frame_cnt_q, err_cnt_q;

    // Statistics: every assembled byte (dropped ones too) and every sync error.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            if (byte_wr)    frame_cnt_q <= frame_cnt_q + CNT_W'(1);
            if (sync_err_d) err_cnt_q   <= err_cnt_q + CNT_W'(1);
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
`endif

endmodule
